// File: rtl/multisim_push_arbiter_if.sv
// multisim_push_arbiter_if: requester-side and push-server-side handshake bundle for the arbiter.
// With MULTISIM_ARB_SRC_TAG_EN defined, out_data carries the source index in its MSBs.
interface multisim_push_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int N_REQ      = 4
);
    localparam int SRC_W = $clog2(N_REQ);
`ifdef MULTISIM_ARB_SRC_TAG_EN
    localparam int OUT_W = DATA_WIDTH + SRC_W;
`else
    localparam int OUT_W = DATA_WIDTH;
`endif
    logic [N_REQ-1:0]            req_vld;
    logic [N_REQ-1:0]            req_rdy;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic                        out_vld;
    logic                        out_rdy;
    logic [OUT_W-1:0]            out_data;
    logic [SRC_W-1:0]            out_src;
    modport master (output req_vld, req_data, out_rdy, input req_rdy, out_vld, out_data, out_src);
    modport slave  (input req_vld, req_data, out_rdy, output req_rdy, out_vld, out_data, out_src);
endinterface

// File: rtl/multisim_push_arbiter.sv
// multisim_push_arbiter: round-robin arbiter with per-owner burst lock feeding one registered push stage.
// Define MULTISIM_ARB_SRC_TAG_EN to prepend the source index to out_data.
module multisim_push_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int N_REQ      = 4,
    parameter int BURST_LEN  = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    multisim_push_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
`ifdef MULTISIM_ARB_SRC_TAG_EN
    localparam int OUT_W = DATA_WIDTH + SRC_W;
`else
    localparam int OUT_W = DATA_WIDTH;
`endif
    typedef enum logic {IDLE, BURST} state_t;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [SRC_W-1:0]      r_owner;
    logic [SRC_W-1:0]      w_owner_nxt;
    logic [SRC_W-1:0]      r_ptr;
    logic [SRC_W-1:0]      w_ptr_nxt;
    logic                  r_out_vld;
    logic [OUT_W-1:0]      r_out_data;
    logic [SRC_W-1:0]      r_out_src;
    logic                  w_can_load;
    logic                  w_own_vld;
    logic                  w_locked;
    logic                  w_rr_hit;
    logic [SRC_W-1:0]      w_rr_idx;
    logic [SRC_W-1:0]      w_sel;
    logic                  w_sel_vld;
    logic                  w_accept;
    logic [N_REQ-1:0]      w_grant;
    logic [DATA_WIDTH-1:0] w_payload;
    logic [OUT_W-1:0]      w_out_word;

    assign w_can_load = !r_out_vld || bus.out_rdy;
    assign w_own_vld  = bus.req_vld[r_owner];
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    // The lowest offset from ptr wins, so scan downward and let the last hit stand.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_vld[(int'(r_ptr) + k) % N_REQ]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = SRC_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    // ptr already equals owner+1 while locked, so a released lock re-arbitrates from there.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_locked    = (r_state == BURST) && (w_own_vld || !w_can_load);
        w_sel       = w_locked ? r_owner : w_rr_idx;
        w_sel_vld   = w_locked ? w_own_vld : w_rr_hit;
        w_accept    = w_sel_vld && w_can_load;
        if (w_accept && w_locked) begin
            w_state_nxt = (w_cnt_inc == CNT_W'(BURST_LEN)) ? IDLE : BURST;
            w_cnt_nxt   = (w_cnt_inc == CNT_W'(BURST_LEN)) ? '0 : w_cnt_inc;
        end else if (w_accept && BURST_LEN > 1) begin
            w_state_nxt = BURST;
            w_cnt_nxt   = CNT_W'(1);
            w_owner_nxt = w_sel;
        end else if (r_state == BURST && !w_locked) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end
    end

    assign w_grant   = w_sel_vld ? (N_REQ'(1) << w_sel) : '0;
    assign w_payload = bus.req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_nxt = (w_sel == SRC_W'(N_REQ - 1)) ? '0 : w_sel + SRC_W'(1);
`ifdef MULTISIM_ARB_SRC_TAG_EN
    assign w_out_word = {w_sel, w_payload};
`else
    assign w_out_word = w_payload;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_src  <= '0;
            r_ptr      <= '0;
        end else if (w_accept) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_out_word;
            r_out_src  <= w_sel;
            r_ptr      <= w_ptr_nxt;
        end else if (bus.out_rdy) begin
            r_out_vld  <= 1'b0;
        end
    end

    // Ready is masked by rst_n so nothing looks accepted while reset is held.
    assign bus.req_rdy  = w_grant & {N_REQ{w_can_load & rst_n}};
    assign bus.out_vld  = r_out_vld;
    assign bus.out_data = r_out_data;
    assign bus.out_src  = r_out_src;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_grant));
    for (genvar g = 0; g < N_REQ; g++) begin : g_proto
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            bus.req_vld[g] && !bus.req_rdy[g] |=>
            bus.req_vld[g] && $stable(bus.req_data[g*DATA_WIDTH +: DATA_WIDTH]));
    end
endmodule

// File: tb/tb_multisim_push_arbiter.sv
// tb_multisim_push_arbiter: table-driven check of two arbiters, BURST_LEN=2 (dut_a) and BURST_LEN=1 (dut_b).
// Requester payloads are fixed: req0=A5, req1=1111, req2=FF, req3=1234.
module tb_multisim_push_arbiter;
`ifdef MULTISIM_ARB_SRC_TAG_EN
    localparam int OUT_W = 66;
`else
    localparam int OUT_W = 64;
`endif
    typedef struct packed {
        logic       b;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] rdy;
        logic       ovld;
        logic [1:0] src;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tv[$];
    logic [63:0] dat [4] = '{64'hA5, 64'h1111, 64'hFF, 64'h1234};

    multisim_push_arbiter_if #(.DATA_WIDTH(64), .N_REQ(4)) ifa ();
    multisim_push_arbiter_if #(.DATA_WIDTH(64), .N_REQ(4)) ifb ();

    multisim_push_arbiter #(.DATA_WIDTH(64), .N_REQ(4), .BURST_LEN(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    multisim_push_arbiter #(.DATA_WIDTH(64), .N_REQ(4), .BURST_LEN(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(logic b, logic [3:0] vld, logic ordy, logic [3:0] rdy, logic ovld, logic [1:0] src);
        return '{b: b, vld: vld, ordy: ordy, rdy: rdy, ovld: ovld, src: src};
    endfunction

    function automatic logic [OUT_W-1:0] exp_d(logic [1:0] s);
`ifdef MULTISIM_ARB_SRC_TAG_EN
        return {s, dat[s]};
`else
        return dat[s];
`endif
    endfunction

    task automatic cmp(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic b, logic [3:0] vld, logic ordy);
        ifa.req_vld = b ? 4'b0 : vld;
        ifa.out_rdy = b ? 1'b1 : ordy;
        ifb.req_vld = b ? vld : 4'b0;
        ifb.out_rdy = b ? ordy : 1'b1;
    endtask

    task automatic check_vec(int i, vec_t t);
        logic [3:0]       rdy;
        logic             ov;
        logic [1:0]       s;
        logic [OUT_W-1:0] d;
        rdy = t.b ? ifb.req_rdy : ifa.req_rdy;
        ov  = t.b ? ifb.out_vld : ifa.out_vld;
        s   = t.b ? ifb.out_src : ifa.out_src;
        d   = t.b ? ifb.out_data : ifa.out_data;
        cmp($sformatf("v%0d req_rdy", i), 128'(rdy), 128'(t.rdy));
        cmp($sformatf("v%0d out_vld", i), 128'(ov), 128'(t.ovld));
        if (t.ovld) begin
            cmp($sformatf("v%0d out_src", i), 128'(s), 128'(t.src));
            cmp($sformatf("v%0d out_data", i), 128'(d), 128'(exp_d(t.src)));
        end
    endtask

    initial begin
        // dut_a, BURST_LEN=2: lone req3, bursts of two, early drop, 5-cycle stall
        tv.push_back(v(0, 4'b1000, 1, 4'b1000, 0, 0));
        tv.push_back(v(0, 4'b0000, 1, 4'b0000, 1, 3));
        tv.push_back(v(0, 4'b0011, 1, 4'b0001, 0, 0));
        tv.push_back(v(0, 4'b0011, 1, 4'b0001, 1, 0));
        tv.push_back(v(0, 4'b0010, 1, 4'b0010, 1, 0));
        tv.push_back(v(0, 4'b0110, 1, 4'b0010, 1, 1));
        tv.push_back(v(0, 4'b0110, 1, 4'b0100, 1, 1));
        tv.push_back(v(0, 4'b0110, 1, 4'b0100, 1, 2));
        tv.push_back(v(0, 4'b0110, 1, 4'b0010, 1, 2));
        tv.push_back(v(0, 4'b0100, 1, 4'b0100, 1, 1));
        tv.push_back(v(0, 4'b0101, 1, 4'b0100, 1, 2));
        tv.push_back(v(0, 4'b0101, 1, 4'b0001, 1, 2));
        for (int i = 0; i < 5; i++) tv.push_back(v(0, 4'b0101, 0, 4'b0000, 1, 0));
        tv.push_back(v(0, 4'b0101, 1, 4'b0001, 1, 0));
        tv.push_back(v(0, 4'b0101, 1, 4'b0100, 1, 0));
        tv.push_back(v(0, 4'b0001, 1, 4'b0001, 1, 2));
        tv.push_back(v(0, 4'b0000, 0, 4'b0000, 1, 0));
        tv.push_back(v(0, 4'b0000, 1, 4'b0000, 1, 0));
        tv.push_back(v(0, 4'b0000, 1, 4'b0000, 0, 0));
        // dut_b, BURST_LEN=1: all valid rotates 0,1,2,3,0,... then drains
        tv.push_back(v(1, 4'b1111, 1, 4'b0001, 0, 0));
        tv.push_back(v(1, 4'b1111, 1, 4'b0010, 1, 0));
        tv.push_back(v(1, 4'b1111, 1, 4'b0100, 1, 1));
        tv.push_back(v(1, 4'b1111, 1, 4'b1000, 1, 2));
        tv.push_back(v(1, 4'b1111, 1, 4'b0001, 1, 3));
        tv.push_back(v(1, 4'b1111, 1, 4'b0010, 1, 0));
        tv.push_back(v(1, 4'b1101, 1, 4'b0100, 1, 1));
        tv.push_back(v(1, 4'b1001, 1, 4'b1000, 1, 2));
        tv.push_back(v(1, 4'b0001, 1, 4'b0001, 1, 3));
        tv.push_back(v(1, 4'b0000, 1, 4'b0000, 1, 0));
        tv.push_back(v(1, 4'b0000, 1, 4'b0000, 0, 0));

        ifa.req_data = {dat[3], dat[2], dat[1], dat[0]};
        ifb.req_data = {dat[3], dat[2], dat[1], dat[0]};
        rst_n = 1'b0;
        drive(0, 4'b1111, 1);
        ifb.req_vld = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        cmp("rst a req_rdy", 128'(ifa.req_rdy), 128'(0));
        cmp("rst b req_rdy", 128'(ifb.req_rdy), 128'(0));
        cmp("rst a out_vld", 128'(ifa.out_vld), 128'(0));
        cmp("rst b out_vld", 128'(ifb.out_vld), 128'(0));
        cmp("rst a out_data", 128'(ifa.out_data), 128'(0));
        cmp("rst a out_src", 128'(ifa.out_src), 128'(0));
        @(negedge clk);
        drive(0, 4'b0000, 1);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].b, tv[i].vld, tv[i].ordy);
            #1;
            check_vec(i, tv[i]);
        end

        // Reset asserted mid-burst on dut_a with out_vld=1
        @(negedge clk);
        drive(0, 4'b0010, 1);
        #1;
        cmp("mid rst grant", 128'(ifa.req_rdy), 128'(4'b0010));
        @(negedge clk);
        #1;
        cmp("mid rst pre out_vld", 128'(ifa.out_vld), 128'(1));
        cmp("mid rst pre out_src", 128'(ifa.out_src), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        cmp("mid rst out_vld", 128'(ifa.out_vld), 128'(0));
        cmp("mid rst req_rdy", 128'(ifa.req_rdy), 128'(0));
        cmp("mid rst out_data", 128'(ifa.out_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 4'b0101, 1);
        #1;
        cmp("post rst grant", 128'(ifa.req_rdy), 128'(4'b0001));
        @(negedge clk);
        drive(0, 4'b0100, 1);
        #1;
        cmp("post rst out_src", 128'(ifa.out_src), 128'(0));
        cmp("post rst out_data", 128'(ifa.out_data), 128'(exp_d(2'd0)));
        cmp("post rst release", 128'(ifa.req_rdy), 128'(4'b0100));
        @(negedge clk);
        drive(0, 4'b0000, 1);
        #1;
        cmp("post rst next src", 128'(ifa.out_src), 128'(2));
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
